// File: rtl/dpram_w1r2_write_arbiter_if.sv
// Bundle between the write requesters / clear controller and the arbiter, including the RAM write port.
interface dpram_w1r2_write_arbiter_if #(
   parameter int unsigned address_width = 10,
   parameter int unsigned data_width    = 8
);
   logic                     req_a_valid;
   logic                     req_a_ready;
   logic [address_width-1:0] req_a_addr;
   logic [data_width-1:0]    req_a_data;
   logic                     req_b_valid;
   logic                     req_b_ready;
   logic [address_width-1:0] req_b_addr;
   logic [data_width-1:0]    req_b_data;
   logic                     clear_start;
   logic [data_width-1:0]    clear_value;
   logic                     clear_busy;
   logic                     last_grant;
   logic                     wren_a;
   logic [address_width-1:0] address_a;
   logic [data_width-1:0]    data_a;

   modport master (
      output req_a_valid, req_a_addr, req_a_data,
      output req_b_valid, req_b_addr, req_b_data,
      output clear_start, clear_value,
      input  req_a_ready, req_b_ready, clear_busy, last_grant,
      input  wren_a, address_a, data_a
   );

   modport slave (
      input  req_a_valid, req_a_addr, req_a_data,
      input  req_b_valid, req_b_addr, req_b_data,
      input  clear_start, clear_value,
      output req_a_ready, req_b_ready, clear_busy, last_grant,
      output wren_a, address_a, data_a
   );
endinterface

// File: rtl/dpram_w1r2_write_arbiter.sv
// Round-robin arbiter for the single write port of a W1R2 dual-port RAM, with an optional
// bulk clear engine built only when DPRAM_WRITE_ARB_CLEAR_EN is defined.
module dpram_w1r2_write_arbiter #(
   parameter int unsigned address_width = 10,
   parameter int unsigned data_width    = 8
) (
   input logic                      clock,
   input logic                      reset_n,
   dpram_w1r2_write_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e                   state_q, state_d;
   logic [address_width:0]   cnt_q, cnt_d;
   logic [data_width-1:0]    clr_val_q, clr_val_d;
   logic                     grant_q, grant_d;
   logic                     wren_q, wren_d;
   logic [address_width-1:0] addr_q, addr_d;
   logic [data_width-1:0]    data_q, data_d;
   logic                     ready_a, ready_b;
   logic                     clear_go;
   logic [data_width-1:0]    clear_in;

`ifdef DPRAM_WRITE_ARB_CLEAR_EN
   assign clear_go = bus.clear_start;
   assign clear_in = bus.clear_value;
`else
   // Clear controls are accepted on the ports but have no effect in this build.
   logic unused_clear;
   assign unused_clear = ^{bus.clear_start, bus.clear_value};
   assign clear_go     = 1'b0;
   assign clear_in     = '0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_val_d = clr_val_q;
      grant_d   = grant_q;
      wren_d    = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      ready_a   = 1'b0;
      ready_b   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clear_go) begin
               state_d   = StClear;
               cnt_d     = '0;
               clr_val_d = clear_in;
            end else begin
               // On contention the requester that lost the previous arbitration wins.
               if (bus.req_a_valid && (!bus.req_b_valid || grant_q)) begin
                  ready_a = 1'b1;
               end else if (bus.req_b_valid) begin
                  ready_b = 1'b1;
               end
               if (ready_a) begin
                  wren_d  = 1'b1;
                  addr_d  = bus.req_a_addr;
                  data_d  = bus.req_a_data;
                  grant_d = 1'b0;
               end else if (ready_b) begin
                  wren_d  = 1'b1;
                  addr_d  = bus.req_b_addr;
                  data_d  = bus.req_b_data;
                  grant_d = 1'b1;
               end
            end
         end
         StClear: begin
            wren_d = 1'b1;
            addr_d = cnt_q[address_width-1:0];
            data_d = clr_val_q;
            cnt_d  = cnt_q + (address_width + 1)'(1);
            // The extra counter bit flags that the top address has just been issued.
            if (cnt_d[address_width]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         clr_val_q <= '0;
         grant_q   <= 1'b0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clr_val_q <= clr_val_d;
         grant_q   <= grant_d;
         wren_q    <= wren_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
      end
   end

   assign bus.req_a_ready = ready_a;
   assign bus.req_b_ready = ready_b;
   assign bus.clear_busy  = (state_q == StClear);
   assign bus.last_grant  = grant_q;
   assign bus.wren_a      = wren_q;
   assign bus.address_a   = addr_q;
   assign bus.data_a      = data_q;

endmodule

// File: tb/tb_dpram_w1r2_write_arbiter.sv
// Randomised self-checking bench for dpram_w1r2_write_arbiter against a behavioural arbitration model.
module tb_dpram_w1r2_write_arbiter;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   dpram_w1r2_write_arbiter_if #(.address_width(AW), .data_width(DW)) bus ();

   dpram_w1r2_write_arbiter #(.address_width(AW), .data_width(DW)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int   total = 0;
   int   bad = 0;
   logic exp_last = 1'b0;  // 0 = A won last arbitration, 1 = B

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_a_valid = 1'b0;
      bus.req_a_addr  = '0;
      bus.req_a_data  = '0;
      bus.req_b_valid = 1'b0;
      bus.req_b_addr  = '0;
      bus.req_b_data  = '0;
      bus.clear_start = 1'b0;
      bus.clear_value = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) tick();
      total++;
      if ({bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant} !== '0) begin
         bad++;
         $display("FAIL reset_in: wren=%b addr=%h data=%h busy=%b last=%b required all 0",
                  bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant);
      end
      reset_n = 1'b1;
      tick();
      total++;
      if ({bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant} !== '0) begin
         bad++;
         $display("FAIL reset_out: wren=%b addr=%h data=%h busy=%b last=%b required all 0",
                  bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant);
      end
      exp_last = 1'b0;
   endtask

   task automatic test_single_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.req_a_valid = 1'b1;
      bus.req_a_addr  = addr;
      bus.req_a_data  = data;
      #1;
      total++;
      if (bus.req_a_ready !== 1'b1 || bus.req_b_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_ready: ra=%b rb=%b required ra=1 rb=0", bus.req_a_ready,
                  bus.req_b_ready);
      end
      tick();
      bus.req_a_valid = 1'b0;
      exp_last = 1'b0;
      total++;
      if (bus.wren_a !== 1'b1 || bus.address_a !== addr || bus.data_a !== data ||
          bus.last_grant !== 1'b0) begin
         bad++;
         $display("FAIL single_write: wren=%b addr=%h data=%h last=%b required 1 %h %h 0",
                  bus.wren_a, bus.address_a, bus.data_a, bus.last_grant, addr, data);
      end
      tick();
      total++;
      if (bus.wren_a !== 1'b0) begin
         bad++;
         $display("FAIL single_idle: wren=%b required 0", bus.wren_a);
      end
   endtask

   task automatic test_alternate();
      logic [AW-1:0] a_addr, b_addr, w_addr;
      logic [DW-1:0] a_data, b_data, w_data;
      logic          win_b;
      a_addr = 10'h100; a_data = 8'h10;
      b_addr = 10'h200; b_data = 8'h20;
      for (int i = 0; i < 4; i++) begin
         bus.req_a_valid = 1'b1; bus.req_a_addr = a_addr; bus.req_a_data = a_data;
         bus.req_b_valid = 1'b1; bus.req_b_addr = b_addr; bus.req_b_data = b_data;
         win_b = (exp_last == 1'b0);  // the loser of the last round goes first
         w_addr = win_b ? b_addr : a_addr;
         w_data = win_b ? b_data : a_data;
         #1;
         total++;
         if (bus.req_b_ready !== win_b || bus.req_a_ready !== !win_b) begin
            bad++;
            $display("FAIL alt_ready[%0d]: ra=%b rb=%b required ra=%b rb=%b", i,
                     bus.req_a_ready, bus.req_b_ready, !win_b, win_b);
         end
         tick();
         exp_last = win_b;
         total++;
         if (bus.wren_a !== 1'b1 || bus.address_a !== w_addr || bus.data_a !== w_data ||
             bus.last_grant !== win_b) begin
            bad++;
            $display("FAIL alt_write[%0d]: wren=%b addr=%h data=%h last=%b required 1 %h %h %b",
                     i, bus.wren_a, bus.address_a, bus.data_a, bus.last_grant, w_addr, w_data,
                     win_b);
         end
         // Only the accepted requester moves on to a fresh transaction.
         if (win_b) begin b_addr++; b_data++; end
         else begin a_addr++; a_data++; end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_random(input int cycles, input bit poke_clear);
      bit            pend_a = 0, pend_b = 0;
      logic          exp_ra, exp_rb;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      for (int i = 0; i < cycles; i++) begin
         if (!pend_a && $urandom_range(0, 2) != 0) begin
            pend_a = 1;
            bus.req_a_addr = AW'($urandom);
            bus.req_a_data = DW'($urandom);
         end
         if (!pend_b && $urandom_range(0, 2) != 0) begin
            pend_b = 1;
            bus.req_b_addr = AW'($urandom);
            bus.req_b_data = DW'($urandom);
         end
         bus.req_a_valid = pend_a;
         bus.req_b_valid = pend_b;
         if (poke_clear) begin
            bus.clear_start = 1'($urandom);
            bus.clear_value = DW'($urandom);
         end
         case ({pend_a, pend_b})
            2'b10:   begin exp_ra = 1; exp_rb = 0; end
            2'b01:   begin exp_ra = 0; exp_rb = 1; end
            2'b11:   begin exp_ra = exp_last; exp_rb = !exp_last; end
            default: begin exp_ra = 0; exp_rb = 0; end
         endcase
         w_addr = exp_ra ? bus.req_a_addr : bus.req_b_addr;
         w_data = exp_ra ? bus.req_a_data : bus.req_b_data;
         #1;
         total++;
         if (bus.req_a_ready !== exp_ra || bus.req_b_ready !== exp_rb) begin
            bad++;
            $display("FAIL rand_ready[%0d]: ra=%b rb=%b required ra=%b rb=%b", i,
                     bus.req_a_ready, bus.req_b_ready, exp_ra, exp_rb);
         end
         tick();
         if (exp_ra) begin exp_last = 1'b0; pend_a = 0; end
         if (exp_rb) begin exp_last = 1'b1; pend_b = 0; end
         total++;
         if (bus.wren_a !== (exp_ra | exp_rb) || bus.last_grant !== exp_last ||
             bus.clear_busy !== 1'b0 ||
             ((exp_ra | exp_rb) && (bus.address_a !== w_addr || bus.data_a !== w_data))) begin
            bad++;
            $display("FAIL rand_write[%0d]: wren=%b addr=%h data=%h last=%b busy=%b required %b %h %h %b 0",
                     i, bus.wren_a, bus.address_a, bus.data_a, bus.last_grant, bus.clear_busy,
                     exp_ra | exp_rb, w_addr, w_data, exp_last);
         end
      end
      idle_inputs();
      tick();
   endtask

`ifdef DPRAM_WRITE_ARB_CLEAR_EN
   task automatic test_clear();
      bus.req_a_valid = 1'b1; bus.req_a_addr = 10'h007; bus.req_a_data = 8'h77;
      bus.clear_start = 1'b1; bus.clear_value = 8'h3C;
      #1;
      total++;
      if (bus.req_a_ready !== 1'b0 || bus.req_b_ready !== 1'b0) begin
         bad++;
         $display("FAIL clear_start_ready: ra=%b rb=%b required 0 0", bus.req_a_ready,
                  bus.req_b_ready);
      end
      tick();
      bus.clear_start = 1'b0;
      bus.clear_value = 8'hFF;
      total++;
      if (bus.clear_busy !== 1'b1 || bus.wren_a !== 1'b0) begin
         bad++;
         $display("FAIL clear_entry: busy=%b wren=%b required 1 0", bus.clear_busy, bus.wren_a);
      end
      for (int i = 0; i < DEPTH; i++) begin
         bus.clear_start = (i == 100);  // must not restart the fill
         #1;
         total++;
         if (bus.req_a_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_ready[%0d]: ra=%b required 0", i, bus.req_a_ready);
         end
         tick();
         total++;
         if (bus.wren_a !== 1'b1 || bus.address_a !== AW'(i) || bus.data_a !== 8'h3C ||
             bus.clear_busy !== (i != DEPTH - 1) || bus.last_grant !== exp_last) begin
            bad++;
            $display("FAIL clear_write[%0d]: wren=%b addr=%h data=%h busy=%b last=%b required 1 %h 3c %b %b",
                     i, bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant,
                     AW'(i), i != DEPTH - 1, exp_last);
         end
      end
      bus.clear_start = 1'b0;
      #1;
      total++;
      if (bus.req_a_ready !== 1'b1) begin
         bad++;
         $display("FAIL clear_after_ready: ra=%b required 1", bus.req_a_ready);
      end
      tick();
      bus.req_a_valid = 1'b0;
      exp_last = 1'b0;
      total++;
      if (bus.wren_a !== 1'b1 || bus.address_a !== 10'h007 || bus.data_a !== 8'h77 ||
          bus.last_grant !== 1'b0) begin
         bad++;
         $display("FAIL clear_after_write: wren=%b addr=%h data=%h last=%b required 1 007 77 0",
                  bus.wren_a, bus.address_a, bus.data_a, bus.last_grant);
      end
      tick();
   endtask

   task automatic test_reset_midclear();
      bus.clear_start = 1'b1; bus.clear_value = 8'h5A;
      tick();
      bus.clear_start = 1'b0;
      for (int i = 0; i <= 500; i++) tick();
      total++;
      if (bus.wren_a !== 1'b1 || bus.address_a !== 10'd500 || bus.data_a !== 8'h5A) begin
         bad++;
         $display("FAIL midclear_pos: wren=%b addr=%h data=%h required 1 1f4 5a", bus.wren_a,
                  bus.address_a, bus.data_a);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant} !== '0) begin
         bad++;
         $display("FAIL midclear_reset: wren=%b addr=%h data=%h busy=%b last=%b required all 0",
                  bus.wren_a, bus.address_a, bus.data_a, bus.clear_busy, bus.last_grant);
      end
      tick();
      reset_n = 1'b1;
      exp_last = 1'b0;
      tick();
      total++;
      if (bus.clear_busy !== 1'b0 || bus.wren_a !== 1'b0) begin
         bad++;
         $display("FAIL midclear_idle: busy=%b wren=%b required 0 0", bus.clear_busy,
                  bus.wren_a);
      end
      test_single_a(10'h3FF, 8'hC3);
   endtask
`else
   task automatic test_clear_ignored();
      bus.clear_start = 1'b1; bus.clear_value = 8'h3C;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (bus.req_a_ready !== 1'b0 || bus.req_b_ready !== 1'b0) begin
            bad++;
            $display("FAIL noclr_ready[%0d]: ra=%b rb=%b required 0 0", i, bus.req_a_ready,
                     bus.req_b_ready);
         end
         tick();
         total++;
         if (bus.clear_busy !== 1'b0 || bus.wren_a !== 1'b0) begin
            bad++;
            $display("FAIL noclr_idle[%0d]: busy=%b wren=%b required 0 0", i, bus.clear_busy,
                     bus.wren_a);
         end
      end
      test_random(60, 1'b1);
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_single_a(10'h005, 8'hA5);
      test_alternate();
      test_random(300, 1'b0);
`ifdef DPRAM_WRITE_ARB_CLEAR_EN
      test_clear();
      test_reset_midclear();
`else
      test_clear_ignored();
`endif
      test_alternate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the end, required completion");
      $fatal(1);
   end
endmodule
